// File: rtl/complete_stage_pkg.sv
// complete_stage_pkg: ROB row layout, instruction type encodings and opcode constants
package complete_stage_pkg;
  localparam int ROB_DEPTH = 16;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [1:0] TYPE_REG = 2'd0;
  localparam logic [1:0] TYPE_STORE = 2'd1;
  localparam logic [1:0] TYPE_LOAD = 2'd2;
  typedef struct packed {
    logic valid;
    logic [1:0] typ;
    logic [5:0] preg;
    logic [5:0] opreg;
    logic [6:0] pc;
    logic [31:0] result;
    logic complete;
  } rob_row;
  function automatic logic [1:0] opc_type(input logic [6:0] opc);
    return opc == OPC_STORE ? TYPE_STORE : opc == OPC_LOAD ? TYPE_LOAD : TYPE_REG;
  endfunction
endpackage

// File: rtl/complete_stage.sv
// complete_stage: 16-entry ROB with 3 completion buses, dual allocate and dual in-order retire
module complete_stage
  import complete_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_flag_ci,
  output logic        en_flag_co,
  input  logic [31:0] result_c1,
  input  logic [5:0]  result_dest_c1,
  input  logic        result_valid_c1,
  input  logic [3:0]  result_ROB_c1,
  input  logic [31:0] result_c2,
  input  logic [5:0]  result_dest_c2,
  input  logic        result_valid_c2,
  input  logic [3:0]  result_ROB_c2,
  input  logic [31:0] result_c3,
  input  logic [5:0]  result_dest_c3,
  input  logic        result_valid_c3,
  input  logic [3:0]  result_ROB_c3,
  input  logic        update_rob,
  input  logic [5:0]  rob_p_reg_1,
  input  logic [6:0]  rob_opcode_1,
  input  logic [6:0]  rob_pc_1,
  input  logic [5:0]  o_rob_p_reg_1,
  input  logic [5:0]  rob_p_reg_2,
  input  logic [6:0]  rob_opcode_2,
  input  logic [6:0]  rob_pc_2,
  input  logic [5:0]  o_rob_p_reg_2,
  output logic [3:0]  rob_tail,
  output logic        rob_full,
  output logic        forward_flag_1,
  output logic [5:0]  dest_R_1,
  output logic [31:0] forwarded_data_1,
  output logic        forward_flag_2,
  output logic [5:0]  dest_R_2,
  output logic [31:0] forwarded_data_2,
  output logic        forward_flag_3,
  output logic [5:0]  dest_R_3,
  output logic [31:0] forwarded_data_3,
  output logic        retire_flag_1,
  output logic [5:0]  fp_ind_1,
  output logic [4:0]  retire_index_1,
  output logic [31:0] retire_result_1,
  output logic        retire_flag_2,
  output logic [5:0]  fp_ind_2,
  output logic [4:0]  retire_index_2,
  output logic [31:0] retire_result_2,
  input  logic [31:0] total_instr_count,
  output logic        pr_flag
);
  rob_row rob_q [ROB_DEPTH];
  rob_row rob_d [ROB_DEPTH];
  logic [3:0] head_q, head_d, tail_q, tail_d, h2;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] ret_cnt_q, ret_cnt_d, last_total_q;
  logic pr_flag_q, pr_done_q, pr_done_d, pr_cond, same_total, en_q;
  logic r1, r2, al1, al2;
  logic [31:0] res [3];
  logic [5:0] dst [3];
  logic [3:0] idx [3];
  logic [2:0] vld, acc, fwd_d, fwd_q;
  logic [5:0] dest_q [3];
  logic [31:0] data_q [3];
  logic [1:0] ret_d, ret_q;
  logic [3:0] sl [2];
  logic [3:0] rix_d [2];
  logic [3:0] rix_q [2];
  logic [5:0] fp_d [2];
  logic [5:0] fp_q [2];
  logic [31:0] rres_d [2];
  logic [31:0] rres_q [2];
  assign res = '{result_c1, result_c2, result_c3};
  assign dst = '{result_dest_c1, result_dest_c2, result_dest_c3};
  assign idx = '{result_ROB_c1, result_ROB_c2, result_ROB_c3};
  assign vld = {result_valid_c3, result_valid_c2, result_valid_c1};
  assign rob_full = cnt_q > 5'(ROB_DEPTH - 2);
  assign rob_tail = tail_q;
  assign en_flag_co = en_q;
  assign pr_flag = pr_flag_q;
  assign {forward_flag_3, forward_flag_2, forward_flag_1} = fwd_q;
  assign dest_R_1 = dest_q[0];
  assign dest_R_2 = dest_q[1];
  assign dest_R_3 = dest_q[2];
  assign forwarded_data_1 = data_q[0];
  assign forwarded_data_2 = data_q[1];
  assign forwarded_data_3 = data_q[2];
  assign {retire_flag_2, retire_flag_1} = ret_q;
  assign fp_ind_1 = fp_q[0];
  assign fp_ind_2 = fp_q[1];
  assign retire_index_1 = {1'b0, rix_q[0]};
  assign retire_index_2 = {1'b0, rix_q[1]};
  assign retire_result_1 = rres_q[0];
  assign retire_result_2 = rres_q[1];
  // Next ROB state: completions first, then retire clears, then allocation into free slots
  always_comb begin
    rob_d = rob_q;
    h2 = head_q + 4'd1;
    r1 = rob_q[head_q].valid & rob_q[head_q].complete;
    r2 = r1 & rob_q[h2].valid & rob_q[h2].complete;
    ret_d = {r2, r1};
    al1 = update_rob & ~rob_full;
    al2 = al1 & (|rob_opcode_2);
    for (int k = 0; k < 3; k++) begin
      acc[k] = vld[k] & rob_q[idx[k]].valid;
      fwd_d[k] = acc[k] & (rob_q[idx[k]].typ != TYPE_STORE);
      if (acc[k]) begin
        rob_d[idx[k]].complete = 1'b1;
        rob_d[idx[k]].result = res[k];
      end
    end
    for (int n = 0; n < 2; n++) begin
      sl[n] = n == 0 ? head_q : h2;
      rix_d[n] = ret_d[n] ? sl[n] : '0;
      fp_d[n] = ret_d[n] && rob_q[sl[n]].typ != TYPE_STORE ? rob_q[sl[n]].opreg : '0;
      rres_d[n] = ret_d[n] ? rob_q[sl[n]].result : '0;
      if (ret_d[n]) begin
        rob_d[sl[n]].valid = 1'b0;
        rob_d[sl[n]].complete = 1'b0;
      end
    end
    if (al1)
      rob_d[tail_q] = '{valid: 1'b1, typ: opc_type(rob_opcode_1), preg: rob_p_reg_1,
                        opreg: o_rob_p_reg_1, pc: rob_pc_1, result: '0, complete: 1'b0};
    if (al2)
      rob_d[tail_q + 4'd1] = '{valid: 1'b1, typ: opc_type(rob_opcode_2), preg: rob_p_reg_2,
                               opreg: o_rob_p_reg_2, pc: rob_pc_2, result: '0, complete: 1'b0};
    head_d = head_q + 4'(r1) + 4'(r2);
    tail_d = tail_q + 4'(al1) + 4'(al2);
    cnt_d = cnt_q + 5'(al1) + 5'(al2) - 5'(r1) - 5'(r2);
    ret_cnt_d = ret_cnt_q + 32'(r1) + 32'(r2);
    same_total = total_instr_count == last_total_q;
    pr_cond = ret_cnt_q == total_instr_count && |total_instr_count && cnt_q == '0 && !(pr_done_q && same_total);
    pr_done_d = pr_cond | (pr_done_q & same_total);
  end
  // Register ROB, pointers, completion broadcast and retire outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rob_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      ret_cnt_q <= '0;
      last_total_q <= '0;
      pr_flag_q <= 1'b0;
      pr_done_q <= 1'b0;
      en_q <= 1'b0;
      fwd_q <= '0;
      dest_q <= '{default: '0};
      data_q <= '{default: '0};
      ret_q <= '0;
      fp_q <= '{default: '0};
      rix_q <= '{default: '0};
      rres_q <= '{default: '0};
    end else begin
      rob_q <= rob_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      ret_cnt_q <= ret_cnt_d;
      last_total_q <= total_instr_count;
      pr_flag_q <= pr_cond;
      pr_done_q <= pr_done_d;
      en_q <= en_flag_ci;
      fwd_q <= fwd_d;
      for (int k = 0; k < 3; k++) begin
        dest_q[k] <= fwd_d[k] ? dst[k] : '0;
        data_q[k] <= fwd_d[k] ? res[k] : '0;
      end
      ret_q <= ret_d;
      fp_q <= fp_d;
      rix_q <= rix_d;
      rres_q <= rres_d;
    end
  end
endmodule

// File: tb/tb_complete_stage.sv
// tb_complete_stage: directed stimulus with queued expectations checked by a negedge monitor
module tb_complete_stage;
  localparam logic [6:0] ADD = 7'b0110011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] LD = 7'b0000011;
  logic clk = 1'b0;
  logic rst_n, en_flag_ci, en_flag_co, update_rob, rob_full, pr_flag;
  logic [31:0] result_c1, result_c2, result_c3, total_instr_count;
  logic [5:0] result_dest_c1, result_dest_c2, result_dest_c3;
  logic result_valid_c1, result_valid_c2, result_valid_c3;
  logic [3:0] result_ROB_c1, result_ROB_c2, result_ROB_c3, rob_tail;
  logic [5:0] rob_p_reg_1, rob_p_reg_2, o_rob_p_reg_1, o_rob_p_reg_2;
  logic [6:0] rob_opcode_1, rob_opcode_2, rob_pc_1, rob_pc_2;
  logic forward_flag_1, forward_flag_2, forward_flag_3;
  logic [5:0] dest_R_1, dest_R_2, dest_R_3;
  logic [31:0] forwarded_data_1, forwarded_data_2, forwarded_data_3;
  logic retire_flag_1, retire_flag_2;
  logic [5:0] fp_ind_1, fp_ind_2;
  logic [4:0] retire_index_1, retire_index_2;
  logic [31:0] retire_result_1, retire_result_2;
  typedef struct {int k; logic [5:0] d; logic [31:0] v;} fwd_t;
  typedef struct {logic [5:0] fp; logic [4:0] ix; logic [31:0] v;} ret_t;
  fwd_t fq [$];
  ret_t rq [$];
  int total = 0;
  int bad = 0;
  int pr_cnt = 0;
  always #5 clk = ~clk;
  complete_stage dut (
    .clk(clk), .rst_n(rst_n), .en_flag_ci(en_flag_ci), .en_flag_co(en_flag_co),
    .result_c1(result_c1), .result_dest_c1(result_dest_c1), .result_valid_c1(result_valid_c1), .result_ROB_c1(result_ROB_c1),
    .result_c2(result_c2), .result_dest_c2(result_dest_c2), .result_valid_c2(result_valid_c2), .result_ROB_c2(result_ROB_c2),
    .result_c3(result_c3), .result_dest_c3(result_dest_c3), .result_valid_c3(result_valid_c3), .result_ROB_c3(result_ROB_c3),
    .update_rob(update_rob),
    .rob_p_reg_1(rob_p_reg_1), .rob_opcode_1(rob_opcode_1), .rob_pc_1(rob_pc_1), .o_rob_p_reg_1(o_rob_p_reg_1),
    .rob_p_reg_2(rob_p_reg_2), .rob_opcode_2(rob_opcode_2), .rob_pc_2(rob_pc_2), .o_rob_p_reg_2(o_rob_p_reg_2),
    .rob_tail(rob_tail), .rob_full(rob_full),
    .forward_flag_1(forward_flag_1), .dest_R_1(dest_R_1), .forwarded_data_1(forwarded_data_1),
    .forward_flag_2(forward_flag_2), .dest_R_2(dest_R_2), .forwarded_data_2(forwarded_data_2),
    .forward_flag_3(forward_flag_3), .dest_R_3(dest_R_3), .forwarded_data_3(forwarded_data_3),
    .retire_flag_1(retire_flag_1), .fp_ind_1(fp_ind_1), .retire_index_1(retire_index_1), .retire_result_1(retire_result_1),
    .retire_flag_2(retire_flag_2), .fp_ind_2(fp_ind_2), .retire_index_2(retire_index_2), .retire_result_2(retire_result_2),
    .total_instr_count(total_instr_count), .pr_flag(pr_flag)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  task automatic mon_fwd(input int k, input logic f, input logic [5:0] d, input logic [31:0] v);
    fwd_t e;
    if (f) begin
      if (fq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fwd%0d_unexpected got dest=%0d data=%0h want none", k, d, v);
      end else begin
        e = fq.pop_front();
        chk($sformatf("fwd%0d_lane", k), k, e.k);
        chk($sformatf("fwd%0d_dest", k), d, e.d);
        chk($sformatf("fwd%0d_data", k), v, e.v);
      end
    end
  endtask
  task automatic mon_ret(input int n, input logic f, input logic [5:0] fp, input logic [4:0] ix, input logic [31:0] v);
    ret_t e;
    if (f) begin
      if (rq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ret%0d_unexpected got idx=%0d want none", n, ix);
      end else begin
        e = rq.pop_front();
        chk($sformatf("ret%0d_fp", n), fp, e.fp);
        chk($sformatf("ret%0d_idx", n), ix, e.ix);
        chk($sformatf("ret%0d_res", n), v, e.v);
      end
    end
  endtask
  always @(negedge clk) begin
    mon_fwd(1, forward_flag_1, dest_R_1, forwarded_data_1);
    mon_fwd(2, forward_flag_2, dest_R_2, forwarded_data_2);
    mon_fwd(3, forward_flag_3, dest_R_3, forwarded_data_3);
    mon_ret(1, retire_flag_1, fp_ind_1, retire_index_1, retire_result_1);
    mon_ret(2, retire_flag_2, fp_ind_2, retire_index_2, retire_result_2);
    if (pr_flag) pr_cnt++;
  end
  task automatic clr();
    en_flag_ci = 0; update_rob = 0;
    result_c1 = 0; result_dest_c1 = 0; result_valid_c1 = 0; result_ROB_c1 = 0;
    result_c2 = 0; result_dest_c2 = 0; result_valid_c2 = 0; result_ROB_c2 = 0;
    result_c3 = 0; result_dest_c3 = 0; result_valid_c3 = 0; result_ROB_c3 = 0;
    rob_p_reg_1 = 0; rob_opcode_1 = 0; rob_pc_1 = 0; o_rob_p_reg_1 = 0;
    rob_p_reg_2 = 0; rob_opcode_2 = 0; rob_pc_2 = 0; o_rob_p_reg_2 = 0;
  endtask
  task automatic alloc(input logic [5:0] p1, input logic [5:0] o1, input logic [6:0] op1,
                       input logic [5:0] p2, input logic [5:0] o2, input logic [6:0] op2);
    update_rob = 1;
    rob_p_reg_1 = p1; o_rob_p_reg_1 = o1; rob_opcode_1 = op1; rob_pc_1 = 7'(p1);
    rob_p_reg_2 = p2; o_rob_p_reg_2 = o2; rob_opcode_2 = op2; rob_pc_2 = 7'(p2);
  endtask
  task automatic res(input int k, input logic [3:0] r, input logic [5:0] d, input logic [31:0] v);
    if (k == 1) begin result_valid_c1 = 1; result_ROB_c1 = r; result_dest_c1 = d; result_c1 = v; end
    if (k == 2) begin result_valid_c2 = 1; result_ROB_c2 = r; result_dest_c2 = d; result_c2 = v; end
    if (k == 3) begin result_valid_c3 = 1; result_ROB_c3 = r; result_dest_c3 = d; result_c3 = v; end
  endtask
  task automatic nxt();
    @(negedge clk);
  endtask
  initial begin
    rst_n = 0; total_instr_count = 0; clr();
    nxt(); nxt();
    chk("rst_tail", rob_tail, 0);
    chk("rst_full", rob_full, 0);
    chk("rst_fwd", {forward_flag_1, forward_flag_2, forward_flag_3}, 0);
    chk("rst_ret", {retire_flag_1, retire_flag_2, fp_ind_1, retire_result_1}, 0);
    chk("rst_pr_en", {pr_flag, en_flag_co}, 0);
    rst_n = 1; en_flag_ci = 1;
    nxt(); chk("en_delay", en_flag_co, 1);
    en_flag_ci = 0;
    alloc(33, 5, ADD, 0, 0, 0);
    nxt(); clr(); chk("t1_tail", rob_tail, 1);
    res(1, 0, 33, 7); fq.push_back('{1, 6'd33, 32'd7}); rq.push_back('{6'd5, 5'd0, 32'd7});
    nxt(); clr();
    chk("t1_fwd_flag", forward_flag_1, 1); chk("t1_fwd_dest", dest_R_1, 33); chk("t1_fwd_data", forwarded_data_1, 7);
    nxt();
    chk("t1_ret_flag", retire_flag_1, 1); chk("t1_fp", fp_ind_1, 5); chk("t1_ret_res", retire_result_1, 7);
    alloc(10, 20, ADD, 11, 21, ADD);
    nxt(); clr(); chk("t2_tail", rob_tail, 3);
    res(2, 2, 11, 32'h22); fq.push_back('{2, 6'd11, 32'h22});
    nxt(); clr(); chk("t2_hold_a", retire_flag_1, 0);
    nxt(); chk("t2_hold_b", retire_flag_1, 0);
    res(3, 1, 10, 32'h11); fq.push_back('{3, 6'd10, 32'h11});
    rq.push_back('{6'd20, 5'd1, 32'h11}); rq.push_back('{6'd21, 5'd2, 32'h22});
    nxt(); clr(); nxt();
    chk("t2_dual_ret", {retire_flag_1, retire_flag_2}, 2'b11);
    res(1, 9, 50, 32'hdead);
    nxt(); clr(); chk("drop_invalid", forward_flag_1, 0);
    alloc(12, 13, ST, 0, 0, 0);
    nxt(); clr(); chk("t3_tail", rob_tail, 4);
    res(1, 3, 12, 32'h55); rq.push_back('{6'd0, 5'd3, 32'h55});
    nxt(); clr(); chk("t3_no_fwd", forward_flag_1, 0);
    nxt(); chk("t3_ret_flag", retire_flag_1, 1); chk("t3_fp0", fp_ind_1, 0);
    alloc(40, 1, ADD, 41, 2, LD);
    nxt(); alloc(42, 3, ADD, 43, 4, ADD);
    nxt(); clr(); chk("t4_tail", rob_tail, 8);
    res(1, 5, 41, 32'h100); res(2, 6, 42, 32'h200); res(3, 7, 43, 32'h300);
    fq.push_back('{1, 6'd41, 32'h100}); fq.push_back('{2, 6'd42, 32'h200}); fq.push_back('{3, 6'd43, 32'h300});
    nxt(); clr();
    chk("t4_three_fwd", {forward_flag_1, forward_flag_2, forward_flag_3}, 3'b111);
    chk("t4_no_ret", retire_flag_1, 0);
    res(1, 4, 40, 32'h400); fq.push_back('{1, 6'd40, 32'h400});
    rq.push_back('{6'd1, 5'd4, 32'h400}); rq.push_back('{6'd2, 5'd5, 32'h100});
    rq.push_back('{6'd3, 5'd6, 32'h200}); rq.push_back('{6'd4, 5'd7, 32'h300});
    nxt(); clr(); nxt();
    chk("t4_ret_pair_a", {retire_flag_1, retire_flag_2}, 2'b11); chk("t4_load_fp", fp_ind_2, 2);
    nxt(); chk("t4_ret_pair_b", {retire_flag_1, retire_flag_2}, 2'b11);
    for (int j = 0; j < 7; j++) begin
      alloc(6'(16 + 2 * j), 6'(1 + 2 * j), ADD, 6'(17 + 2 * j), 6'(2 + 2 * j), ADD);
      nxt();
    end
    clr(); chk("t5_tail14", rob_tail, 6); chk("t5_notfull14", rob_full, 0);
    alloc(30, 15, ADD, 31, 16, ADD);
    nxt(); clr(); chk("t5_full", rob_full, 1); chk("t5_tail16", rob_tail, 8);
    alloc(60, 61, ADD, 62, 63, ADD);
    nxt(); clr(); chk("t5_ignored_tail", rob_tail, 8); chk("t5_still_full", rob_full, 1);
    for (int m = 0; m < 16; m++) rq.push_back('{6'(1 + m), 5'((8 + m) % 16), 32'hA000 + m});
    for (int g = 0; g < 16; g += 3) begin
      for (int k = 0; k < 3 && g + k < 16; k++) begin
        res(k + 1, 4'((8 + g + k) % 16), 6'(16 + g + k), 32'hA000 + g + k);
        fq.push_back('{k + 1, 6'(16 + g + k), 32'hA000 + g + k});
      end
      nxt(); clr();
    end
    repeat (10) nxt();
    chk("t5_drained_full", rob_full, 0); chk("t5_drained_tail", rob_tail, 8);
    alloc(1, 2, ADD, 3, 4, ADD);
    nxt(); clr();
    res(1, 8, 1, 32'hbeef); rst_n = 0;
    nxt(); clr();
    chk("rst_mid_fwd", forward_flag_1, 0); chk("rst_mid_tail", rob_tail, 0);
    chk("rst_mid_ret", {retire_flag_1, retire_flag_2, pr_flag, rob_full}, 0);
    nxt(); rst_n = 1;
    total_instr_count = 4;
    alloc(20, 30, ADD, 21, 31, ADD);
    nxt(); alloc(22, 32, ADD, 23, 33, ADD);
    nxt(); clr(); chk("t7_tail", rob_tail, 4);
    res(1, 0, 20, 1); res(2, 1, 21, 2); res(3, 2, 22, 3);
    fq.push_back('{1, 6'd20, 32'd1}); fq.push_back('{2, 6'd21, 32'd2}); fq.push_back('{3, 6'd22, 32'd3});
    rq.push_back('{6'd30, 5'd0, 32'd1}); rq.push_back('{6'd31, 5'd1, 32'd2});
    rq.push_back('{6'd32, 5'd2, 32'd3}); rq.push_back('{6'd33, 5'd3, 32'd4});
    nxt(); clr();
    res(1, 3, 23, 4); fq.push_back('{1, 6'd23, 32'd4});
    nxt(); clr();
    repeat (8) nxt();
    chk("pr_pulses", pr_cnt, 1);
    chk("fwd_queue_empty", fq.size(), 0);
    chk("ret_queue_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
